// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: shared word type, branch queue entry and helpers
package branch_resolve_unit_pkg;
  typedef logic [31:0] word_t;
  typedef struct packed {
    word_t pc;
    word_t pred_pc;
  } bq_entry_t;
  localparam word_t PC_STEP  = 32'd4;
  localparam word_t WORD_MAX = 32'hFFFF_FFFF;
  function automatic word_t sat_inc(word_t v, logic en);
    return (en && v != WORD_MAX) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: fetch, EX resolve, redirect and predictor-update signals
interface branch_resolve_unit_if;
  import branch_resolve_unit_pkg::*;
  logic  fetch_valid;
  word_t fetch_PC;
  word_t fetch_pred_PC;
  logic  q_full;
  logic  ex_valid;
  logic  ex_is_branch;
  logic  ex_taken;
  word_t ex_target;
  logic  redirect;
  word_t redirect_PC;
  logic  upd_wen;
  word_t upd_PC;
  word_t upd_target_PC;
  logic  upd_taken;
  word_t br_count;
  word_t mispredict_count;
  modport master (
    output fetch_valid, fetch_PC, fetch_pred_PC, ex_valid, ex_is_branch, ex_taken, ex_target,
    input  q_full, redirect, redirect_PC, upd_wen, upd_PC, upd_target_PC, upd_taken,
           br_count, mispredict_count
  );
  modport slave (
    input  fetch_valid, fetch_PC, fetch_pred_PC, ex_valid, ex_is_branch, ex_taken, ex_target,
    output q_full, redirect, redirect_PC, upd_wen, upd_PC, upd_target_PC, upd_taken,
           br_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolve_unit_branch_queue.sv
// branch_queue: in-order FIFO of fetched PCs and their predictions; flush beats push
module branch_queue
  import branch_resolve_unit_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  bq_entry_t                data_i,
  output bq_entry_t                head_o,
  output logic [$clog2(QDEPTH):0]  count_o,
  output logic                     full_o
);
  localparam int PTR_W = $clog2(QDEPTH);
  bq_entry_t        mem_q [QDEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;
  assign full_o  = count_q == (PTR_W+1)'(QDEPTH);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];
  // next pointers and occupancy; a flush empties the queue outright
  always_comb begin
    push_ok = push_i && !full_o && !flush_i;
    pop_ok  = pop_i && count_q != '0;
    rd_d    = flush_i ? '0 : rd_q + PTR_W'(pop_ok);
    wr_d    = flush_i ? '0 : wr_q + PTR_W'(push_ok);
    count_d = flush_i ? '0 : count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
  end
  // pointer and count registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end
  // entry storage; contents beyond count are don't-care so no reset
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: checks predictions at EX, issues redirects and predictor updates
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input logic                   CLK,
  input logic                   nRST,
  branch_resolve_unit_if.slave  brif
);
  localparam int PTR_W = $clog2(QDEPTH);
  bq_entry_t      head, fetch_entry;
  logic [PTR_W:0] count;
  logic           full, push, pop, flush_now;
  word_t          actual;
  logic           redirect_q, redirect_d, upd_wen_q, upd_wen_d, upd_taken_q, upd_taken_d;
  word_t          redirect_pc_q, redirect_pc_d, upd_pc_q, upd_pc_d, upd_tgt_q, upd_tgt_d;
  word_t          br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
  assign fetch_entry = '{pc: brif.fetch_PC, pred_pc: brif.fetch_pred_PC};
  branch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .CLK     (CLK),
    .nRST    (nRST),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_now),
    .data_i  (fetch_entry),
    .head_o  (head),
    .count_o (count),
    .full_o  (full)
  );
  // resolve the head against EX, decide push/flush, build the one-cycle output pulses
  always_comb begin
    pop           = brif.ex_valid && count != '0 && !redirect_q;
    actual        = (brif.ex_is_branch && brif.ex_taken) ? brif.ex_target : head.pc + PC_STEP;
    flush_now     = pop && actual != head.pred_pc;
    push          = brif.fetch_valid && !full && !flush_now && !redirect_q;
    redirect_d    = flush_now;
    redirect_pc_d = pop ? actual : '0;
    upd_wen_d     = pop && brif.ex_is_branch;
    upd_pc_d      = pop ? head.pc : '0;
    upd_tgt_d     = pop ? brif.ex_target : '0;
    upd_taken_d   = pop && brif.ex_taken;
    br_cnt_d      = sat_inc(br_cnt_q, pop && brif.ex_is_branch);
    mis_cnt_d     = sat_inc(mis_cnt_q, flush_now);
  end
  // output and statistics registers; reset drops any pending redirect/update
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      upd_wen_q     <= 1'b0;
      upd_pc_q      <= '0;
      upd_tgt_q     <= '0;
      upd_taken_q   <= 1'b0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      upd_wen_q     <= upd_wen_d;
      upd_pc_q      <= upd_pc_d;
      upd_tgt_q     <= upd_tgt_d;
      upd_taken_q   <= upd_taken_d;
      br_cnt_q      <= br_cnt_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end
  assign brif.q_full           = full;
  assign brif.redirect         = redirect_q;
  assign brif.redirect_PC      = redirect_pc_q;
  assign brif.upd_wen          = upd_wen_q;
  assign brif.upd_PC           = upd_pc_q;
  assign brif.upd_target_PC    = upd_tgt_q;
  assign brif.upd_taken        = upd_taken_q;
  assign brif.br_count         = br_cnt_q;
  assign brif.mispredict_count = mis_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vector table plus reset and saturation sequences
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;
  typedef struct {
    logic fv; word_t fpc, fpred;
    logic ev, eb, et; word_t etgt;
    logic r; word_t rpc;
    logic w; word_t upc, utgt;
    logic ut, qf; int cnt; word_t br, mis;
  } vec_t;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t v [31];
  branch_resolve_unit_if bus();
  branch_resolve_unit #(.QDEPTH(4)) dut (.CLK(CLK), .nRST(nRST), .brif(bus));
  always #5 CLK = ~CLK;
  function automatic vec_t inp(logic fv, word_t fpc, word_t fpred, logic ev, logic eb, logic et, word_t etgt);
    vec_t x;
    x = '{default: '0};
    x.fv = fv; x.fpc = fpc; x.fpred = fpred; x.ev = ev; x.eb = eb; x.et = et; x.etgt = etgt;
    return x;
  endfunction
  function automatic vec_t ex(vec_t x, logic r, word_t rpc, logic w, word_t upc, word_t utgt,
                              logic ut, logic qf, int cnt, word_t br, word_t mis);
    vec_t y;
    y = x;
    y.r = r; y.rpc = rpc; y.w = w; y.upc = upc; y.utgt = utgt;
    y.ut = ut; y.qf = qf; y.cnt = cnt; y.br = br; y.mis = mis;
    return y;
  endfunction
  task automatic drive(vec_t x);
    bus.fetch_valid = x.fv; bus.fetch_PC = x.fpc; bus.fetch_pred_PC = x.fpred;
    bus.ex_valid = x.ev; bus.ex_is_branch = x.eb; bus.ex_taken = x.et; bus.ex_target = x.etgt;
  endtask
  task automatic chk(string tag, string f, word_t act, word_t exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %h expected %h", tag, f, act, exp);
    end
  endtask
  task automatic check(string tag, vec_t e);
    n_vec++;
    chk(tag, "redirect", 32'(bus.redirect), 32'(e.r));
    chk(tag, "redirect_PC", bus.redirect_PC, e.rpc);
    chk(tag, "upd_wen", 32'(bus.upd_wen), 32'(e.w));
    chk(tag, "upd_PC", bus.upd_PC, e.upc);
    chk(tag, "upd_target_PC", bus.upd_target_PC, e.utgt);
    chk(tag, "upd_taken", 32'(bus.upd_taken), 32'(e.ut));
    chk(tag, "q_full", 32'(bus.q_full), 32'(e.qf));
    chk(tag, "count", 32'(dut.u_queue.count_q), 32'(e.cnt));
    chk(tag, "br_count", bus.br_count, e.br);
    chk(tag, "mispredict_count", bus.mispredict_count, e.mis);
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    vec_t idle, z;
    idle = inp(0, 0, 0, 0, 0, 0, 0);
    v[0]  = ex(inp(1, 32'h100, 32'h104, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    v[1]  = ex(inp(0, 0, 0, 1, 0, 0, 0), 0, 32'h104, 0, 32'h100, 0, 0, 0, 0, 0, 0);
    v[2]  = ex(inp(1, 32'h200, 32'h204, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    v[3]  = ex(inp(0, 0, 0, 1, 1, 1, 32'h300), 1, 32'h300, 1, 32'h200, 32'h300, 1, 0, 0, 1, 1);
    v[4]  = ex(idle, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    v[5]  = ex(inp(1, 32'h40, 32'h80, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    v[6]  = ex(inp(0, 0, 0, 1, 1, 0, 32'h80), 1, 32'h44, 1, 32'h40, 32'h80, 0, 0, 0, 2, 2);
    v[7]  = ex(inp(1, 32'h1000, 32'h1004, 1, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0, 2, 2);
    v[8]  = ex(inp(1, 32'h20, 32'h24, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 1, 2, 2);
    v[9]  = ex(inp(1, 32'h24, 32'h28, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 2, 2, 2);
    v[10] = ex(inp(1, 32'h28, 32'h2C, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 3, 2, 2);
    v[11] = ex(inp(1, 32'h2C, 32'h30, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 1, 4, 2, 2);
    v[12] = ex(inp(1, 32'h30, 32'h34, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 1, 4, 2, 2);
    v[13] = ex(inp(1, 32'h34, 32'h38, 1, 0, 0, 0), 0, 32'h24, 0, 32'h20, 0, 0, 0, 3, 2, 2);
    v[14] = ex(inp(1, 32'h30, 32'h34, 1, 0, 0, 0), 0, 32'h28, 0, 32'h24, 0, 0, 0, 3, 2, 2);
    v[15] = ex(inp(0, 0, 0, 1, 1, 1, 32'h2C), 0, 32'h2C, 1, 32'h28, 32'h2C, 1, 0, 2, 3, 2);
    v[16] = ex(inp(0, 0, 0, 1, 0, 0, 0), 0, 32'h30, 0, 32'h2C, 0, 0, 0, 1, 3, 2);
    v[17] = ex(inp(0, 0, 0, 1, 0, 0, 0), 0, 32'h34, 0, 32'h30, 0, 0, 0, 0, 3, 2);
    v[18] = ex(inp(0, 0, 0, 1, 1, 1, 32'h999), 0, 0, 0, 0, 0, 0, 0, 0, 3, 2);
    v[19] = ex(inp(1, 32'h10, 32'h14, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 1, 3, 2);
    v[20] = ex(inp(1, 32'h14, 32'h18, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 2, 3, 2);
    v[21] = ex(inp(1, 32'h18, 32'h1C, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 3, 3, 2);
    v[22] = ex(inp(1, 32'h60, 32'h64, 1, 1, 1, 32'h50), 1, 32'h50, 1, 32'h10, 32'h50, 1, 0, 0, 4, 3);
    v[23] = ex(inp(1, 32'h70, 32'h74, 1, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0, 4, 3);
    v[24] = ex(inp(1, 32'h500, 32'h504, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 1, 4, 3);
    v[25] = ex(inp(0, 0, 0, 1, 0, 0, 0), 0, 32'h504, 0, 32'h500, 0, 0, 0, 0, 4, 3);
    v[26] = ex(inp(1, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 1, 4, 3);
    v[27] = ex(inp(0, 0, 0, 1, 1, 0, 32'h1234), 0, 32'h0, 1, 32'hFFFF_FFFC, 32'h1234, 0, 0, 0, 5, 3);
    v[28] = ex(inp(1, 32'hFFFF_FFFC, 32'h8, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 1, 5, 3);
    v[29] = ex(inp(0, 0, 0, 1, 0, 0, 0), 1, 32'h0, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 5, 4);
    v[30] = ex(idle, 0, 0, 0, 0, 0, 0, 0, 0, 5, 4);
    drive(idle);
    #12;
    check("reset", ex(idle, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    nRST = 1'b1;
    for (int i = 0; i < 31; i++) begin
      drive(v[i]);
      step();
      check($sformatf("vec%0d", i), v[i]);
    end
    drive(inp(1, 32'h10, 32'h14, 0, 0, 0, 0));
    step();
    drive(inp(1, 32'h14, 32'h18, 0, 0, 0, 0));
    step();
    check("rst_pre", ex(idle, 0, 0, 0, 0, 0, 0, 0, 2, 5, 4));
    drive(inp(0, 0, 0, 1, 1, 1, 32'h90));
    #3 nRST = 1'b0;
    #1 check("rst_async", ex(idle, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 nRST = 1'b1;
    step();
    check("rst_dropped", ex(idle, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    force dut.br_cnt_q = 32'hFFFF_FFFE;
    force dut.mis_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.br_cnt_q;
    release dut.mis_cnt_q;
    drive(inp(1, 32'h700, 32'h704, 0, 0, 0, 0));
    step();
    drive(inp(0, 0, 0, 1, 1, 1, 32'h800));
    step();
    check("sat_hit", ex(idle, 1, 32'h800, 1, 32'h700, 32'h800, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    drive(idle);
    step();
    drive(inp(1, 32'h720, 32'h724, 0, 0, 0, 0));
    step();
    drive(inp(0, 0, 0, 1, 1, 1, 32'h900));
    step();
    z = ex(idle, 1, 32'h900, 1, 32'h720, 32'h900, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("sat_hold", z);
    drive(idle);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
